// File: rtl/vmu_pkg.sv
// Shared encodings, system defaults and FSM state type
// for the vector memory unit address generator.
package vmu_pkg;

  localparam int SYS_NUM_LSU         = 3;
  localparam int SYS_SCALAR_WIDTH    = 32;
  localparam int SYS_CONFIG_OP_WIDTH = 3;
  localparam int SYS_VLMAX           = 64;
  localparam int SYS_NUM_LANE        = 4;
  localparam int COMMON_AGEN_DELAY   = 2;

  localparam logic [1:0] VMU_OP_NOP   = 2'd0;
  localparam logic [1:0] VMU_OP_LOAD  = 2'd1;
  localparam logic [1:0] VMU_OP_STORE = 2'd2;
  localparam int VMU_MODE_STRIDE_BIT  = 2;

  localparam int VMU_CFG_STRIDE  = 1;
  localparam int VMU_CFG_MODULUS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } vmu_agen_state_e;

endpackage

// File: rtl/vmu_agen_ch.sv
// One LSU channel: snapshot of op/base, wrapping offset
// and a stallable output pipeline of strobes and addresses.
module vmu_agen_ch
  import vmu_pkg::*;
#(
  parameter int AW  = 32,
  parameter int OPW = 3,
  parameter int DLY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic [OPW-1:0] i_op,
  input  logic [AW-1:0]  i_base,
  input  logic [AW-1:0]  i_stride,
  input  logic [AW-1:0]  i_mod,
  input  logic           i_issue,
  input  logic           i_stall,
  output logic           o_rden,
  output logic           o_wren,
  output logic [AW-1:0]  o_rdaddr,
  output logic [AW-1:0]  o_wraddr
);

  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  base_q, base_d;
  logic [AW-1:0]  off_q, off_d;
  logic [AW-1:0]  step, addr;
  logic [AW:0]    sum;
  logic           is_ld, is_st;

  logic          rden_q [DLY];
  logic          rden_d [DLY];
  logic          wren_q [DLY];
  logic          wren_d [DLY];
  logic [AW-1:0] rda_q  [DLY];
  logic [AW-1:0] rda_d  [DLY];
  logic [AW-1:0] wra_q  [DLY];
  logic [AW-1:0] wra_d  [DLY];

  always_comb begin
    op_d   = op_q;
    base_d = base_q;
    off_d  = off_q;
    step   = op_q[VMU_MODE_STRIDE_BIT] ? i_stride : AW'(1);
    sum    = {1'b0, off_q} + {1'b0, step};
    addr   = base_q + off_q;
    is_ld  = (op_q[1:0] == VMU_OP_LOAD);
    is_st  = (op_q[1:0] == VMU_OP_STORE);
    if (i_load) begin
      op_d   = i_op;
      base_d = i_base;
      off_d  = '0;
    end else if (i_issue) begin
      // zero modulus disables the circular wrap
      if (i_mod != '0 && sum >= {1'b0, i_mod})
        off_d = AW'(sum - {1'b0, i_mod});
      else
        off_d = sum[AW-1:0];
    end
  end

  always_comb begin
    for (int s = 0; s < DLY; s++) begin
      rden_d[s] = rden_q[s];
      wren_d[s] = wren_q[s];
      rda_d[s]  = rda_q[s];
      wra_d[s]  = wra_q[s];
      if (!i_stall) begin
        if (s == 0) begin
          rden_d[s] = i_issue && is_ld;
          wren_d[s] = i_issue && is_st;
          rda_d[s]  = (i_issue && is_ld) ? addr : '0;
          wra_d[s]  = (i_issue && is_st) ? addr : '0;
        end else begin
          rden_d[s] = rden_q[s-1];
          wren_d[s] = wren_q[s-1];
          rda_d[s]  = rda_q[s-1];
          wra_d[s]  = wra_q[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      base_q <= '0;
      off_q  <= '0;
      for (int s = 0; s < DLY; s++) begin
        rden_q[s] <= 1'b0;
        wren_q[s] <= 1'b0;
        rda_q[s]  <= '0;
        wra_q[s]  <= '0;
      end
    end else begin
      op_q   <= op_d;
      base_q <= base_d;
      off_q  <= off_d;
      for (int s = 0; s < DLY; s++) begin
        rden_q[s] <= rden_d[s];
        wren_q[s] <= wren_d[s];
        rda_q[s]  <= rda_d[s];
        wra_q[s]  <= wra_d[s];
      end
    end
  end

  assign o_rden   = rden_q[DLY-1];
  assign o_wren   = wren_q[DLY-1];
  assign o_rdaddr = rda_q[DLY-1];
  assign o_wraddr = wra_q[DLY-1];

endmodule

// File: rtl/vmu_agen_multi.sv
// Multi-channel VMU address generator: command FSM,
// beat counter, config registers and done pipeline.
module vmu_agen_multi
  import vmu_pkg::*;
#(
  parameter int NUM_LSU         = SYS_NUM_LSU,
  parameter int SCALAR_WIDTH    = SYS_SCALAR_WIDTH,
  parameter int LSU_OP_WIDTH    = 3,
  parameter int CONFIG_OP_WIDTH = SYS_CONFIG_OP_WIDTH,
  parameter int CNT_WIDTH       = $clog2(SYS_VLMAX/SYS_NUM_LANE),
  parameter int AGEN_DELAY      = COMMON_AGEN_DELAY
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_seq_vmu_op_vld,
  output logic                       o_vmu_op_rdy,
  input  logic [CNT_WIDTH-1:0]       i_seq_vmu_cnt,
  input  logic [LSU_OP_WIDTH-1:0]    i_seq_vmu_op_ls     [NUM_LSU],
  input  logic [SCALAR_WIDTH-1:0]    i_seq_vmu_scalar_ls [NUM_LSU],
  input  logic [CONFIG_OP_WIDTH-1:0] i_seq_vxu_op_config,
  input  logic [SCALAR_WIDTH-1:0]    i_seq_vxu_scalar_config,
  input  logic                       i_spm_stall,
  output logic                       o_vmu_spm_rden   [NUM_LSU],
  output logic                       o_vmu_spm_wren   [NUM_LSU],
  output logic [SCALAR_WIDTH-1:0]    o_vmu_spm_rdaddr [NUM_LSU],
  output logic [SCALAR_WIDTH-1:0]    o_vmu_spm_wraddr [NUM_LSU],
  output logic                       o_vmu_done
);

  vmu_agen_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SCALAR_WIDTH-1:0] stride_q, stride_d;
  logic [SCALAR_WIDTH-1:0] mod_q, mod_d;
  logic [SCALAR_WIDTH-1:0] sstride_q, sstride_d;
  logic [SCALAR_WIDTH-1:0] smod_q, smod_d;
  logic                    pend_q, pend_d;
  logic [AGEN_DELAY-1:0]   done_q, done_d;

  logic accept, issue, last, inject;

  assign accept = (state_q == ST_IDLE) && i_seq_vmu_op_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (i_seq_vmu_op_vld)
          state_d = (i_seq_vmu_cnt == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:
        if (!i_spm_stall && cnt_q == CNT_WIDTH'(1))
          state_d = ST_DRAIN;
      ST_DRAIN:
        if (!i_spm_stall && done_q[AGEN_DELAY-1])
          state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_vmu_op_rdy = (state_q == ST_IDLE);
    issue        = (state_q == ST_RUN) && !i_spm_stall;
    last         = issue && (cnt_q == CNT_WIDTH'(1));
    // a zero-beat command still sends a lone done token
    inject       = (state_q == ST_DRAIN) && pend_q && !i_spm_stall;
  end

  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    sstride_d = sstride_q;
    smod_d    = smod_q;
    stride_d  = stride_q;
    mod_d     = mod_q;
    done_d    = done_q;
    if (accept) begin
      cnt_d     = i_seq_vmu_cnt;
      pend_d    = (i_seq_vmu_cnt == '0);
      sstride_d = stride_q;
      smod_d    = mod_q;
    end else begin
      if (issue)  cnt_d  = cnt_q - CNT_WIDTH'(1);
      if (inject) pend_d = 1'b0;
    end
    if (i_seq_vxu_op_config == CONFIG_OP_WIDTH'(VMU_CFG_STRIDE))
      stride_d = i_seq_vxu_scalar_config;
    if (i_seq_vxu_op_config == CONFIG_OP_WIDTH'(VMU_CFG_MODULUS))
      mod_d = i_seq_vxu_scalar_config;
    if (!i_spm_stall) begin
      done_d[0] = last || inject;
      for (int s = 1; s < AGEN_DELAY; s++)
        done_d[s] = done_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      sstride_q <= SCALAR_WIDTH'(1);
      smod_q    <= '0;
      stride_q  <= SCALAR_WIDTH'(1);
      mod_q     <= '0;
      done_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      sstride_q <= sstride_d;
      smod_q    <= smod_d;
      stride_q  <= stride_d;
      mod_q     <= mod_d;
      done_q    <= done_d;
    end
  end

  assign o_vmu_done = done_q[AGEN_DELAY-1];

  for (genvar g = 0; g < NUM_LSU; g++) begin : g_ch
    vmu_agen_ch #(
      .AW  (SCALAR_WIDTH),
      .OPW (LSU_OP_WIDTH),
      .DLY (AGEN_DELAY)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (accept),
      .i_op     (i_seq_vmu_op_ls[g]),
      .i_base   (i_seq_vmu_scalar_ls[g]),
      .i_stride (sstride_q),
      .i_mod    (smod_q),
      .i_issue  (issue),
      .i_stall  (i_spm_stall),
      .o_rden   (o_vmu_spm_rden[g]),
      .o_wren   (o_vmu_spm_wren[g]),
      .o_rdaddr (o_vmu_spm_rdaddr[g]),
      .o_wraddr (o_vmu_spm_wraddr[g])
    );
  end

endmodule

// File: tb/tb_vmu_agen_multi.sv
// Directed bench for vmu_agen_multi: table of commands
// plus stall and mid-command reset sequences.
module tb_vmu_agen_multi;

  localparam int NL   = 3;
  localparam int SW   = 32;
  localparam int OPW  = 3;
  localparam int CFW  = 3;
  localparam int CNTW = 4;
  localparam int D    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            vld = 1'b0;
  logic            rdy;
  logic [CNTW-1:0] cnt = '0;
  logic [OPW-1:0]  op_ls   [NL];
  logic [SW-1:0]   base_ls [NL];
  logic [CFW-1:0]  cfg_op = '0;
  logic [SW-1:0]   cfg_data = '0;
  logic            stall = 1'b0;
  logic            rden [NL];
  logic            wren [NL];
  logic [SW-1:0]   rda  [NL];
  logic [SW-1:0]   wra  [NL];
  logic            done;

  always #5 clk = ~clk;

  vmu_agen_multi #(
    .NUM_LSU         (NL),
    .SCALAR_WIDTH    (SW),
    .LSU_OP_WIDTH    (OPW),
    .CONFIG_OP_WIDTH (CFW),
    .CNT_WIDTH       (CNTW),
    .AGEN_DELAY      (D)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_seq_vmu_op_vld        (vld),
    .o_vmu_op_rdy            (rdy),
    .i_seq_vmu_cnt           (cnt),
    .i_seq_vmu_op_ls         (op_ls),
    .i_seq_vmu_scalar_ls     (base_ls),
    .i_seq_vxu_op_config     (cfg_op),
    .i_seq_vxu_scalar_config (cfg_data),
    .i_spm_stall             (stall),
    .o_vmu_spm_rden          (rden),
    .o_vmu_spm_wren          (wren),
    .o_vmu_spm_rdaddr        (rda),
    .o_vmu_spm_wraddr        (wra),
    .o_vmu_done              (done)
  );

  typedef struct packed {
    logic                    cfg;
    logic                    acc_cfg;
    logic [SW-1:0]           stride;
    logic [SW-1:0]           modulus;
    logic [NL-1:0][OPW-1:0]  op;
    logic [NL-1:0][SW-1:0]   base;
    logic [CNTW-1:0]         cnt;
    logic [NL-1:0]           rd;
    logic [NL-1:0]           wr;
    logic [NL-1:0][5:0][SW-1:0] ea;
  } vec_t;

  vec_t vecs [6];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [SW-1:0] act,
                     input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic done_e,
                           input logic rdy_e,
                           input logic [NL-1:0] rd_e,
                           input logic [NL-1:0] wr_e,
                           input logic [NL-1:0][SW-1:0] ra_e,
                           input logic [NL-1:0][SW-1:0] wa_e);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("%s ch%0d rden", tag, i), SW'(rden[i]), SW'(rd_e[i]));
      chk($sformatf("%s ch%0d wren", tag, i), SW'(wren[i]), SW'(wr_e[i]));
      chk($sformatf("%s ch%0d rdaddr", tag, i), rda[i], ra_e[i]);
      chk($sformatf("%s ch%0d wraddr", tag, i), wra[i], wa_e[i]);
    end
    chk({tag, " done"}, SW'(done), SW'(done_e));
    chk({tag, " rdy"}, SW'(rdy), SW'(rdy_e));
  endtask

  task automatic cfg_write(input logic [SW-1:0] s, input logic [SW-1:0] m);
    @(negedge clk);
    cfg_op = 3'd1; cfg_data = s;
    @(negedge clk);
    cfg_op = 3'd2; cfg_data = m;
    @(negedge clk);
    cfg_op = 3'd0; cfg_data = '0;
  endtask

  task automatic start_cmd(input vec_t v);
    @(negedge clk);
    vld = 1'b1;
    cnt = v.cnt;
    for (int i = 0; i < NL; i++) begin
      op_ls[i]   = v.op[i];
      base_ls[i] = v.base[i];
    end
    if (v.acc_cfg) begin
      cfg_op = 3'd1; cfg_data = 32'd9;
    end
    @(negedge clk);
    vld = 1'b0;
    cfg_op = 3'd0;
    cfg_data = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int donej;
    logic [NL-1:0] rd, wr;
    logic [NL-1:0][SW-1:0] ra, wa;
    if (v.cfg) cfg_write(v.stride, v.modulus);
    start_cmd(v);
    donej = (v.cnt == 0) ? D : D + int'(v.cnt) - 1;
    for (int j = 0; j <= donej + 1; j++) begin
      rd = '0; wr = '0; ra = '0; wa = '0;
      if (j >= D && j < D + int'(v.cnt)) begin
        rd = v.rd;
        wr = v.wr;
        for (int i = 0; i < NL; i++) begin
          if (v.rd[i]) ra[i] = v.ea[i][j-D];
          if (v.wr[i]) wa[i] = v.ea[i][j-D];
        end
      end
      check_all($sformatf("%s j%0d", tag, j), j == donej, j > donej,
                rd, wr, ra, wa);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [NL-1:0][SW-1:0] z;
    logic [SW-1:0] sa [10];
    z = '0;
    for (int i = 0; i < NL; i++) begin
      op_ls[i] = '0;
      base_ls[i] = '0;
    end

    for (int n = 0; n < 6; n++) vecs[n] = '0;
    vecs[0].cfg = 1'b1; vecs[0].stride = 32'd1;
    vecs[0].op[0] = 3'b001; vecs[0].base[0] = 32'd128;
    vecs[0].cnt = 4'd4; vecs[0].rd = 3'b001;
    vecs[0].ea[0][0] = 32'd128; vecs[0].ea[0][1] = 32'd129;
    vecs[0].ea[0][2] = 32'd130; vecs[0].ea[0][3] = 32'd131;

    vecs[1].cfg = 1'b1; vecs[1].stride = 32'd8;
    vecs[1].op[0] = 3'b110; vecs[1].base[0] = 32'h100;
    vecs[1].cnt = 4'd3; vecs[1].wr = 3'b001;
    vecs[1].ea[0][0] = 32'h100; vecs[1].ea[0][1] = 32'h108;
    vecs[1].ea[0][2] = 32'h110;

    vecs[2].cfg = 1'b1; vecs[2].stride = 32'd3; vecs[2].modulus = 32'd8;
    vecs[2].op[0] = 3'b101; vecs[2].base[0] = 32'd0;
    vecs[2].cnt = 4'd5; vecs[2].rd = 3'b001;
    vecs[2].ea[0][0] = 32'd0; vecs[2].ea[0][1] = 32'd3;
    vecs[2].ea[0][2] = 32'd6; vecs[2].ea[0][3] = 32'd1;
    vecs[2].ea[0][4] = 32'd4;

    vecs[3].cfg = 1'b1; vecs[3].stride = 32'd3; vecs[3].modulus = 32'd8;
    vecs[3].op[0] = 3'b001; vecs[3].base[0] = 32'h20;
    vecs[3].op[1] = 3'b110; vecs[3].base[1] = 32'h40;
    vecs[3].op[2] = 3'b000; vecs[3].base[2] = 32'h99;
    vecs[3].cnt = 4'd4; vecs[3].rd = 3'b001; vecs[3].wr = 3'b010;
    vecs[3].ea[0][0] = 32'h20; vecs[3].ea[0][1] = 32'h21;
    vecs[3].ea[0][2] = 32'h22; vecs[3].ea[0][3] = 32'h23;
    vecs[3].ea[1][0] = 32'h40; vecs[3].ea[1][1] = 32'h43;
    vecs[3].ea[1][2] = 32'h46; vecs[3].ea[1][3] = 32'h41;

    vecs[4].op[0] = 3'b001; vecs[4].base[0] = 32'd5;
    vecs[4].op[1] = 3'b111; vecs[4].base[1] = 32'd7;
    vecs[4].cnt = 4'd0;

    // after reset: stride must be back to 1; same-cycle write ignored
    vecs[5].acc_cfg = 1'b1;
    vecs[5].op[0] = 3'b101; vecs[5].base[0] = 32'h10;
    vecs[5].cnt = 4'd2; vecs[5].rd = 3'b001;
    vecs[5].ea[0][0] = 32'h10; vecs[5].ea[0][1] = 32'h11;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset", 1'b0, 1'b1, '0, '0, z, z);

    for (int n = 0; n < 5; n++)
      run_vec(vecs[n], $sformatf("vec%0d", n));

    // stall for two cycles right after beat 1 is shown
    cfg_write(32'd1, 32'd0);
    v = '0;
    v.op[0] = 3'b001; v.base[0] = 32'h200; v.cnt = 4'd4;
    sa[2] = 32'h200; sa[3] = 32'h201; sa[4] = 32'h201;
    sa[5] = 32'h201; sa[6] = 32'h202; sa[7] = 32'h203;
    start_cmd(v);
    for (int j = 0; j <= 8; j++) begin
      logic [NL-1:0][SW-1:0] ra;
      logic [NL-1:0] rd;
      ra = '0; rd = '0;
      if (j >= 2 && j <= 7) begin
        rd[0] = 1'b1;
        ra[0] = sa[j];
      end
      check_all($sformatf("stall j%0d", j), j == 7, j == 8, rd, '0, ra, z);
      if (j == 3) stall = 1'b1;
      if (j == 5) stall = 1'b0;
      @(negedge clk);
    end

    // reset after two beats of a stride-5 command
    cfg_write(32'd5, 32'd0);
    v = '0;
    v.op[0] = 3'b101; v.base[0] = 32'd0; v.cnt = 4'd6;
    sa[2] = 32'd0; sa[3] = 32'd5;
    start_cmd(v);
    for (int j = 0; j <= 3; j++) begin
      logic [NL-1:0][SW-1:0] ra;
      logic [NL-1:0] rd;
      ra = '0; rd = '0;
      if (j >= 2) begin
        rd[0] = 1'b1;
        ra[0] = sa[j];
      end
      check_all($sformatf("rst j%0d", j), 1'b0, 1'b0, rd, '0, ra, z);
      if (j == 3) rst_n = 1'b0;
      @(negedge clk);
    end
    check_all("rst after", 1'b0, 1'b1, '0, '0, z, z);
    rst_n = 1'b1;
    run_vec(vecs[5], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
